// File: rtl/psubsb_seq_pkg.sv
// ============================================================================
// Module   : psubsb_seq_pkg
// Purpose  : Shared constants for the sequential packed saturating subtractor.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package psubsb_seq_pkg;

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_RUN  = 2'b01;
    localparam logic [1:0] c_DONE = 2'b10;

    localparam int c_LANES  = 4;
    localparam int c_LANE_W = 4;

    localparam logic [3:0] c_SAT_POS = 4'h7;
    localparam logic [3:0] c_SAT_NEG = 4'h8;

endpackage

`default_nettype wire

// File: rtl/psubsb_seq_subsb_4bit.sv
// ============================================================================
// Module   : subsb_4bit
// Purpose  : Combinational 4-bit signed subtract with saturation to [-8, 7].
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module subsb_4bit
    import psubsb_seq_pkg::*;
(
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] Diff,
    output logic       Ovfl
);

    logic [3:0] w_t;

    assign w_t  = A + ~B + 4'd1;
    // Overflow only possible when operand signs differ and the result flips sign
    assign Ovfl = (A[3] != B[3]) && (w_t[3] != A[3]);
    assign Diff = Ovfl ? (A[3] ? c_SAT_NEG : c_SAT_POS) : w_t;

endmodule

`default_nettype wire

// File: rtl/psubsb_seq.sv
// ============================================================================
// Module   : psubsb_seq
// Purpose  : Multicycle packed 4x4-bit saturating subtract, one lane per cycle,
//            valid/ready on both sides. PSUBSB_OVFL_EN builds per-lane flags.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module psubsb_seq
    import psubsb_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Diff,
    output logic [3:0]  Ovfl
);

    logic [1:0]  r_state;
    logic [1:0]  r_lane;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_diff;

    logic [3:0]  w_lane_a;
    logic [3:0]  w_lane_b;
    logic [3:0]  w_lane_diff;
    logic        w_lane_ovfl;
    logic        w_accept;

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign w_accept  = in_valid && in_ready;
    assign Diff      = r_diff;

    assign w_lane_a = r_a[{r_lane, 2'b00} +: c_LANE_W];
    assign w_lane_b = r_b[{r_lane, 2'b00} +: c_LANE_W];

    subsb_4bit u_slice (
        .A    (w_lane_a),
        .B    (w_lane_b),
        .Diff (w_lane_diff),
        .Ovfl (w_lane_ovfl)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_lane  <= 2'd0;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_diff  <= 16'h0000;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_diff  <= 16'h0000;
                        r_lane  <= 2'd0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_diff[{r_lane, 2'b00} +: c_LANE_W] <= w_lane_diff;
                    r_lane <= r_lane + 2'd1;
                    if (r_lane == 2'd3) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef PSUBSB_OVFL_EN
    logic [3:0] r_ovfl;

    // Flags follow the same clear/write/hold timing as the result nibbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovfl <= 4'h0;
        end else if (w_accept) begin
            r_ovfl <= 4'h0;
        end else if (r_state == c_RUN) begin
            r_ovfl[r_lane] <= w_lane_ovfl;
        end
    end

    assign Ovfl = r_ovfl;
`else
    logic w_unused_ovfl;

    assign w_unused_ovfl = w_lane_ovfl;
    assign Ovfl          = 4'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_psubsb_seq.sv
// ============================================================================
// Module   : tb_psubsb_seq
// Purpose  : Scoreboard bench for psubsb_seq; honours PSUBSB_OVFL_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_psubsb_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Diff;
    logic [3:0]  Ovfl;

    typedef struct packed {
        logic [15:0] diff;
        logic [3:0]  ovfl;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_errors;

    psubsb_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Ovfl      (Ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer subtract per lane, then clamp
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t r;
        r.diff = 16'h0000;
        r.ovfl = 4'h0;
        for (int i = 0; i < 4; i++) begin
            int sa;
            int sb;
            int d;
            logic [3:0] na;
            logic [3:0] nb;
            logic [3:0] nd;
            na = a[i*4 +: 4];
            nb = b[i*4 +: 4];
            sa = na[3] ? int'(na) - 16 : int'(na);
            sb = nb[3] ? int'(nb) - 16 : int'(nb);
            d  = sa - sb;
            if (d > 7) begin
                d = 7;
                r.ovfl[i] = 1'b1;
            end else if (d < -8) begin
                d = -8;
                r.ovfl[i] = 1'b1;
            end
            nd = d[3:0];
            r.diff[i*4 +: 4] = nd;
        end
`ifndef PSUBSB_OVFL_EN
        r.ovfl = 4'h0;
`endif
        return r;
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int hold);
        int   n;
        exp_t e;
        logic [15:0] held_diff;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_before_accept", in_ready, 1'b1);
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        out_ready = (hold == 0);
        sb_q.push_back(model(a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        A        = 16'($urandom);
        B        = 16'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("latency", n, 4);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check("diff", Diff, e.diff);
            check("ovfl", Ovfl, e.ovfl);
        end
        check("in_ready_in_done", in_ready, 1'b0);
        held_diff = Diff;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            A        = 16'($urandom);
            B        = 16'($urandom);
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_diff", Diff, held_diff);
            check("hold_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (hold != 0) begin
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check("in_ready_after_hs", in_ready, 1'b1);
        check("out_valid_after_hs", out_valid, 1'b0);
        check("diff_held_after_hs", Diff, held_diff);
    endtask

    initial begin
        exp_t e;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 16'h0000;
        B         = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_diff", Diff, 16'h0000);
        check("rst_ovfl", Ovfl, 4'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(16'h1234, 16'h4321, 0);
        do_op(16'h7777, 16'hFFFF, 0);
        do_op(16'h8888, 16'h1111, 0);
        do_op(16'h7080, 16'hF010, 0);
        do_op(16'h7080, 16'hF010, 3);

        // Abort mid-RUN: lanes 0 and 1 written, then asynchronous reset
        in_valid = 1'b1;
        A        = 16'h1234;
        B        = 16'h4321;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e = model(16'h1234, 16'h4321);
        check("partial_diff", Diff, {8'h00, e.diff[7:0]});
        check("partial_out_valid", out_valid, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_diff", Diff, 16'h0000);
        check("abort_ovfl", Ovfl, 4'h0);
        check("abort_in_ready", in_ready, 1'b1);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(16'h0000, 16'h0000, 0);

        for (int i = 0; i < 8; i++) begin
            do_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
        end

        check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
